// File: rtl/sr595_arbiter.sv
// Round-robin arbiter sharing one 74hc595 shift-register driver among NREQ requesters.
// Optional WAIT-state abort is enabled by defining SR595_ARB_TIMEOUT_EN.
module sr595_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned INIT_WAIT   = 64,
    parameter int unsigned TIMEOUT_CYC = 63
) (
    input  logic              i_clk,
    input  logic              i_Rst_n,
    input  logic [NREQ-1:0]   i_Req,
    input  logic [8*NREQ-1:0] i_Data,
    output logic [NREQ-1:0]   o_Grant,
    output logic [NREQ-1:0]   o_Ack,
    output logic              o_Busy,
    output logic              o_Timeout,
    output logic              o_SR_Enable,
    output logic [7:0]        o_SR_Data,
    input  logic              i_SR_Ready
);

    localparam int unsigned PtrW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntMax = (INIT_WAIT > TIMEOUT_CYC) ? INIT_WAIT : TIMEOUT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StStart,
        StGuard,
        StWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              en_q, en_d;
    logic [7:0]        data_q, data_d;
    logic              found;
    logic [PtrW-1:0]   win;
    logic [PtrW-1:0]   cand;

    // Search begins one past the last served index.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = PtrW'((int'(ptr_q) + i) % int'(NREQ));
            if (!found && i_Req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef SR595_ARB_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ack_d   = '0;
        en_d    = 1'b0;
        data_d  = data_q;
`ifdef SR595_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StInit: begin
                if (cnt_q == CntW'(INIT_WAIT - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    idx_d        = win;
                    data_d       = i_Data[{win, 3'b000} +: 8];
                    en_d         = 1'b1;
                    state_d      = StStart;
                end
            end
            StStart: state_d = StGuard;
            // Driver drops ready during this cycle; it is not looked at here.
            StGuard: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (i_SR_Ready) begin
                    ack_d   = grant_q;
                    ptr_d   = idx_q;
                    state_d = StDone;
`ifdef SR595_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = idx_q;
                    cnt_d     = '0;
                    state_d   = StInit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            // Points at the last index so index 0 wins the first search.
            ptr_q   <= PtrW'(NREQ - 1);
            idx_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

`ifdef SR595_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign o_Timeout = timeout_q;
`else
    assign o_Timeout = 1'b0;
`endif

    assign o_Grant     = grant_q;
    assign o_Ack       = ack_q;
    assign o_Busy      = busy_q;
    assign o_SR_Enable = en_q;
    assign o_SR_Data   = data_q;

endmodule

// File: tb/tb_sr595_arbiter.sv
// Scoreboard bench for sr595_arbiter with a behavioural 74hc595 driver model.
module tb_sr595_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned INIT_WAIT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   o_Grant, o_Ack;
    logic              o_Busy, o_Timeout, o_SR_Enable;
    logic [7:0]        o_SR_Data;

    // Driver model: drops ready one cycle after sampling enable, shifts 8 bits MSB-first,
    // raises ready again 42 edges after the enable sample.
    logic        drv_rdy = 1'b1;
    logic        drv_busy = 1'b0;
    int          drv_cnt = 0;
    logic [7:0]  drv_sh = '0;
    logic [7:0]  ser_byte = '0;
    int          en_while_busy = 0;
    logic        stall = 1'b0;

    sr595_arbiter #(.NREQ(NREQ), .INIT_WAIT(INIT_WAIT), .TIMEOUT_CYC(63)) dut (
        .i_clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Req       (req),
        .i_Data      (data),
        .o_Grant     (o_Grant),
        .o_Ack       (o_Ack),
        .o_Busy      (o_Busy),
        .o_Timeout   (o_Timeout),
        .o_SR_Enable (o_SR_Enable),
        .o_SR_Data   (o_SR_Data),
        .i_SR_Ready  (drv_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_SR_Enable) begin
            if (drv_busy) en_while_busy <= en_while_busy + 1;
            drv_busy <= 1'b1;
            drv_cnt  <= 1;
            drv_sh   <= o_SR_Data;
            ser_byte <= '0;
        end else if (drv_busy) begin
            if (drv_cnt == 1) drv_rdy <= 1'b0;
            if ((drv_cnt % 5) == 4 && drv_cnt < 40) begin
                ser_byte <= {ser_byte[6:0], drv_sh[7]};
                drv_sh   <= {drv_sh[6:0], 1'b0};
            end
            if (drv_cnt >= 42 && !stall) begin
                drv_rdy  <= 1'b1;
                drv_busy <= 1'b0;
            end else if (drv_cnt < 42) begin
                drv_cnt <= drv_cnt + 1;
            end
        end
    end

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0]      en_data;
    logic [NREQ-1:0] en_grant;
    logic [NREQ-1:0] ack_seen;
    int              en_run;
    int              en_max;

    // Steps negedges until enable (want_ack=0) or an ack (want_ack=1); cyc=-1 on expiry.
    task automatic step_until(input bit want_ack, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (o_SR_Enable) begin
                en_run++;
                if (en_run > en_max) en_max = en_run;
                en_data  = o_SR_Data;
                en_grant = o_Grant;
            end else begin
                en_run = 0;
            end
            if (want_ack ? (o_Ack != '0) : o_SR_Enable) begin
                cyc      = i;
                ack_seen = o_Ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        exp_t e;
        logic [NREQ-1:0] oh;
        rst_n = 1'b0;
        req   = '0;
        data  = {8'h00, 8'h00, 8'h00, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_Grant, o_Ack, o_Busy, o_Timeout, o_SR_Enable, o_SR_Data} !== '0)
                $display("FAIL reset_outputs: got %h required 0",
                         {o_Grant, o_Ack, o_Busy, o_Timeout, o_SR_Enable, o_SR_Data});
            else n_pass++;
        end
        req = 4'b0001;
        exp_q.push_back('{idx: 0, data: 8'h3C});
        rst_n = 1'b1;
        en_run = 0;
        en_max = 0;
        @(negedge clk);
        n_checks++;
        if (o_Busy !== 1'b1) $display("FAIL init_busy: got %b required 1", o_Busy);
        else n_pass++;
        step_until(1'b0, 200, c);
        if (c > 0) c = c + 1;
        n_checks++;
        if (c !== int'(INIT_WAIT) + 1)
            $display("FAIL init_enable_cycle: got %0d required %0d", c, INIT_WAIT + 1);
        else n_pass++;
        n_checks++;
        if (o_SR_Data !== 8'h3C) $display("FAIL init_data: got %h required 3c", o_SR_Data);
        else n_pass++;
        req = '0;
        step_until(1'b1, 100, c);
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.idx;
        n_checks++;
        if (ack_seen !== oh || en_data !== e.data)
            $display("FAIL init_ack: got ack %b data %h required ack %b data %h",
                     ack_seen, en_data, oh, e.data);
        else n_pass++;
    endtask

    task automatic test_single();
        int c1, c2;
        exp_t e;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        data = {8'h00, 8'h00, 8'hA5, 8'h00};
        req  = 4'b0010;
        exp_q.push_back('{idx: 1, data: 8'hA5});
        en_run = 0;
        en_max = 0;
        step_until(1'b0, 10, c1);
        n_checks++;
        if (c1 !== 1) $display("FAIL single_enable_cycle: got %0d required 1", c1);
        else n_pass++;
        req = '0;
        step_until(1'b1, 100, c2);
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.idx;
        n_checks++;
        if (ack_seen !== oh || en_data !== e.data)
            $display("FAIL single_ack: got ack %b data %h required ack %b data %h",
                     ack_seen, en_data, oh, e.data);
        else n_pass++;
        // Enable at cycle 1, ready seen in WAIT at cycle 44, DONE at cycle 45.
        n_checks++;
        if (c2 < 0 || c1 + c2 != 45)
            $display("FAIL single_latency: got %0d required 45", c1 + c2);
        else n_pass++;
        n_checks++;
        if (en_max !== 1) $display("FAIL single_enable_width: got %0d required 1", en_max);
        else n_pass++;
        n_checks++;
        if (ser_byte !== 8'hA5) $display("FAIL single_serial: got %h required a5", ser_byte);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o_Ack !== '0 || o_Grant !== '0)
            $display("FAIL single_ack_pulse: got ack %b grant %b required 0 0", o_Ack, o_Grant);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int c;
        exp_t e;
        logic [NREQ-1:0] oh;
        rst_n = 1'b0;
        @(negedge clk);
        req  = 4'b1111;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        exp_q.push_back('{idx: 0, data: 8'h11});
        exp_q.push_back('{idx: 1, data: 8'h22});
        exp_q.push_back('{idx: 2, data: 8'h33});
        exp_q.push_back('{idx: 3, data: 8'h44});
        exp_q.push_back('{idx: 0, data: 8'h11});
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_until(1'b0, (k == 0) ? 200 : 10, c);
            if (k > 0) begin
                n_checks++;
                if (c < 1 || c > 2) $display("FAIL fair_gap%0d: got %0d required <=2", k, c);
                else n_pass++;
            end
            step_until(1'b1, 100, c);
            if (k == 4) req = '0;
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.idx;
            n_checks++;
            if (ack_seen !== oh || en_data !== e.data)
                $display("FAIL fair_order%0d: got ack %b data %h required ack %b data %h",
                         k, ack_seen, en_data, oh, e.data);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        int c;
        exp_t e;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        data = {8'h00, 8'h5A, 8'h00, 8'h00};
        req  = 4'b0100;
        exp_q.push_back('{idx: 2, data: 8'h5A});
        step_until(1'b0, 10, c);
        repeat (5) @(negedge clk);
        req = '0;
        step_until(1'b1, 100, c);
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.idx;
        n_checks++;
        if (c < 0 || ack_seen !== oh || en_data !== e.data)
            $display("FAIL drop_ack: got ack %b data %h required ack %b data %h",
                     ack_seen, en_data, oh, e.data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int c;
        @(negedge clk);
        data = {8'h77, 8'h00, 8'h00, 8'h00};
        req  = 4'b1000;
        step_until(1'b0, 10, c);
        repeat (5) @(negedge clk);
        req = '0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_Grant, o_Ack, o_Busy, o_Timeout, o_SR_Enable, o_SR_Data} !== '0)
            $display("FAIL wait_reset_outputs: got %h required 0",
                     {o_Grant, o_Ack, o_Busy, o_Timeout, o_SR_Enable, o_SR_Data});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step_until(1'b1, 120, c);
        n_checks++;
        if (c !== -1) $display("FAIL wait_reset_no_ack: got ack at %0d required none", c);
        else n_pass++;
        n_checks++;
        if (o_Busy !== 1'b0) $display("FAIL wait_reset_idle: got busy %b required 0", o_Busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int c;
        int bad;
        stall = 1'b1;
        @(negedge clk);
        data = {8'h00, 8'h00, 8'h00, 8'hC3};
        req  = 4'b0001;
`ifdef SR595_ARB_TIMEOUT_EN
        bad = 0;
        c   = -1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (i > 1) req = '0;
            if (o_Ack != '0) bad++;
            if (o_Timeout && c < 0) c = i;
        end
        n_checks++;
        if (c !== 66) $display("FAIL timeout_cycle: got %0d required 66", c);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL timeout_no_ack: got %0d acks required 0", bad);
        else n_pass++;
        stall = 1'b0;
        req   = 4'b0001;
        step_until(1'b0, 100, c);
        n_checks++;
        if (c < 0 || en_grant !== 4'b0001)
            $display("FAIL timeout_regrant: got %b required 0001", en_grant);
        else n_pass++;
        req = '0;
        step_until(1'b1, 100, c);
`else
        step_until(1'b0, 10, c);
        req = '0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_Busy !== 1'b1 || o_Ack !== '0 || o_Timeout !== 1'b0) bad++;
        end
        n_checks++;
        if (c < 0 || bad !== 0)
            $display("FAIL stall_busy_hold: got %0d bad cycles required 0", bad);
        else n_pass++;
        rst_n = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (INIT_WAIT + 2) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_drop();
        test_reset_in_wait();
        test_stall();
        n_checks++;
        if (en_while_busy !== 0)
            $display("FAIL enable_while_driver_busy: got %0d required 0", en_while_busy);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
